// File: rtl/ibpl_seq_pkg.sv
// ibpl_seq_pkg: shared state type and direction encoding for the
// interbackplane direction sequencer.
package ibpl_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BREAK  = 3'd1,
    SETTLE = 3'd2,
    MAKE   = 3'd3,
    FAULT  = 3'd4
  } seq_state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

endpackage

// File: rtl/ibpl_settle_timer.sv
// ibpl_settle_timer: loadable down-counter that times the break-before-make
// settle window; zero is high once the loaded count has run out.
module ibpl_settle_timer #(
  parameter int SETTLE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int W = $clog2(SETTLE_CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(SETTLE_CYC - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ibpl_dir_sequencer.sv
// ibpl_dir_sequencer: break-before-make owner of the cardlet enable vectors.
// Optional plugin_error watchdog is built with IBPL_SEQ_WATCHDOG_EN.
module ibpl_dir_sequencer
  import ibpl_seq_pkg::*;
#(
  parameter int N_CH       = 6,
  parameter int SETTLE_CYC = 16,
  parameter int ERR_CYC    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [N_CH-1:0] cfg_dir,
  input  logic [N_CH-1:0] cfg_en,
  input  logic            plugin_error,
  output logic [N_CH-1:0] input_enable,
  output logic [N_CH-1:0] output_enable,
  output logic            busy,
  output logic            done,
  output logic            fault
);

  seq_state_t state;

  logic [N_CH-1:0] tgt_in;
  logic [N_CH-1:0] tgt_out;
  logic [N_CH-1:0] chg;
  logic [N_CH-1:0] nxt_in;
  logic [N_CH-1:0] nxt_out;
  logic [N_CH-1:0] nxt_chg;
  logic            accept;
  logic            trip;
  logic            settle_zero;

  always_comb begin
    nxt_in  = '0;
    nxt_out = '0;
    for (int c = 0; c < N_CH; c++) begin
      nxt_in[c]  = cfg_en[c] && (cfg_dir[c] == DIR_IN);
      nxt_out[c] = cfg_en[c] && (cfg_dir[c] == DIR_OUT);
    end
  end

  assign nxt_chg = (nxt_in ^ input_enable)
                 | (nxt_out ^ output_enable);

  assign busy      = (state != IDLE);
  assign cfg_ready = (state == IDLE) && !trip;
  assign accept    = cfg_valid && cfg_ready;

  ibpl_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(state == BREAK),
    .en  (state == SETTLE),
    .zero(settle_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tgt_in        <= '0;
      tgt_out       <= '0;
      chg           <= '0;
      input_enable  <= '0;
      output_enable <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
`ifdef IBPL_SEQ_WATCHDOG_EN
          if (trip) begin
            input_enable  <= '0;
            output_enable <= '0;
            state         <= FAULT;
          end else
`endif
          if (accept) begin
            tgt_in  <= nxt_in;
            tgt_out <= nxt_out;
            chg     <= nxt_chg;
            if (nxt_chg != '0) begin
              state <= BREAK;
            end else begin
              done <= 1'b1;
            end
          end
        end
        BREAK: begin
          input_enable  <= input_enable & ~chg;
          output_enable <= output_enable & ~chg;
          state         <= SETTLE;
        end
        SETTLE: begin
          if (settle_zero) begin
            state <= MAKE;
          end
        end
        MAKE: begin
          // Untouched channels keep their live value; changed ones take target.
          input_enable  <= (input_enable & ~chg) | (tgt_in & chg);
          output_enable <= (output_enable & ~chg) | (tgt_out & chg);
          done          <= 1'b1;
          state         <= IDLE;
        end
`ifdef IBPL_SEQ_WATCHDOG_EN
        FAULT: begin
          state <= FAULT;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef IBPL_SEQ_WATCHDOG_EN

  localparam int EW = $clog2(ERR_CYC + 1);

  logic [EW-1:0] err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((state != IDLE) || !plugin_error) begin
      err_cnt <= '0;
    end else if (!trip) begin
      err_cnt <= err_cnt + EW'(1);
    end
  end

  assign trip = (state == IDLE) && (err_cnt == EW'(ERR_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (trip) begin
      fault <= 1'b1;
    end
  end

`else

  localparam int err_cyc_unused = ERR_CYC;

  logic err_unused;

  assign err_unused = plugin_error;
  assign trip       = 1'b0;
  assign fault      = 1'b0;

`endif

endmodule

// File: tb/tb_ibpl_dir_sequencer.sv
// tb_ibpl_dir_sequencer: directed scenarios checked against a timestamp
// model of the break-before-make sequence plus literal expectations.
module tb_ibpl_dir_sequencer;

  localparam int N  = 6;
  localparam int S  = 4;
  localparam int EC = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         plugin_error = 1'b0;
  logic [N-1:0] cfg_dir = '0;
  logic [N-1:0] cfg_en = '0;
  logic         cfg_ready;
  logic         busy;
  logic         done;
  logic         fault;
  logic [N-1:0] input_enable;
  logic [N-1:0] output_enable;

  int n_checks = 0;
  int n_err    = 0;

  ibpl_dir_sequencer #(
    .N_CH      (N),
    .SETTLE_CYC(S),
    .ERR_CYC   (EC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_dir      (cfg_dir),
    .cfg_en       (cfg_en),
    .plugin_error (plugin_error),
    .input_enable (input_enable),
    .output_enable(output_enable),
    .busy         (busy),
    .done         (done),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: events are edge numbers computed from the acceptance edge.
  int           k = 0;
  bit           started = 0;
  logic [N-1:0] m_in = '0;
  logic [N-1:0] m_out = '0;
  logic [N-1:0] m_tin = '0;
  logic [N-1:0] m_tout = '0;
  logic [N-1:0] m_chg = '0;
  int           free_at = 0;
  int           off_edge = -1;
  int           make_edge = -1;
  int           done_edge = -1;
  int           acc_edge = -1;
  int           m_err = 0;
  bit           m_fault = 0;

  task automatic step();
    bit idle;
    k++;
    if (rst) begin
      m_in = '0;
      m_out = '0;
      free_at = k + 1;
      off_edge = -1;
      make_edge = -1;
      done_edge = -1;
      m_err = 0;
      m_fault = 0;
      started = 1;
      return;
    end
    if (!started) return;
    idle = (k >= free_at);
    if (k == off_edge) begin
      m_in  = m_in & ~m_chg;
      m_out = m_out & ~m_chg;
    end
    if (k == make_edge) begin
      m_in  = (m_in & ~m_chg) | (m_tin & m_chg);
      m_out = (m_out & ~m_chg) | (m_tout & m_chg);
      done_edge = k;
    end
`ifdef IBPL_SEQ_WATCHDOG_EN
    if (idle && m_err >= EC) begin
      m_in = '0;
      m_out = '0;
      m_fault = 1;
      free_at = 32'h7fff_ffff;
    end else
`endif
    if (idle && cfg_valid) begin
      m_tin  = cfg_en & ~cfg_dir;
      m_tout = cfg_en & cfg_dir;
      m_chg  = (m_tin ^ m_in) | (m_tout ^ m_out);
      acc_edge = k;
      if (m_chg == '0) begin
        done_edge = k;
        free_at = k + 1;
      end else begin
        off_edge = k + 1;
        make_edge = k + S + 2;
        free_at = k + S + 3;
      end
    end
`ifdef IBPL_SEQ_WATCHDOG_EN
    if (idle && plugin_error && !m_fault)
      m_err = (m_err < EC) ? m_err + 1 : m_err;
    else
      m_err = 0;
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk);
      step();
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("input_enable", 32'(input_enable), 32'(m_in));
      chk("output_enable", 32'(output_enable), 32'(m_out));
      chk("done", 32'(done), 32'(done_edge == k));
      chk("busy", 32'(busy), 32'(k + 1 < free_at));
      chk("cfg_ready", 32'(cfg_ready),
          32'((k + 1 >= free_at) && (m_err < EC)));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("invariant", 32'(input_enable & output_enable), 0);
    end
  end

  int done_cnt = 0;
  int off_cnt = 0;
  int stable_bad = 0;
  bit scen2 = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (scen2) begin
      if ((input_enable[0] | output_enable[0]) == 1'b0) off_cnt++;
      if (input_enable[5:1] != 5'b01111) stable_bad++;
      if (output_enable[5:1] != 5'b10000) stable_bad++;
    end
  end

  task automatic req(input logic [N-1:0] en, input logic [N-1:0] dir);
    bit got;
    got = 0;
    @(negedge clk);
    cfg_en = en;
    cfg_dir = dir;
    cfg_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (acc_edge == k) begin
        got = 1;
        break;
      end
    end
    cfg_valid = 1'b0;
    chk("req_accept", 32'(got), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit saw_nr;
    bit acc_done;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in", 32'(input_enable), 0);
    chk("rst_out", 32'(output_enable), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);

    // All enabled, channel 5 output.
    done_cnt = 0;
    req(6'h3F, 6'h20);
    repeat (5) @(posedge clk);
    #1;
    chk("s1_pre_in", 32'(input_enable), 0);
    chk("s1_pre_out", 32'(output_enable), 0);
    @(posedge clk);
    #1;
    chk("s1_in", 32'(input_enable), 32'h1F);
    chk("s1_out", 32'(output_enable), 32'h20);
    repeat (2) @(negedge clk);
    chk("s1_done_cnt", done_cnt, 1);

    // Flip channel 0 to output only.
    off_cnt = 0;
    stable_bad = 0;
    done_cnt = 0;
    scen2 = 1;
    req(6'h3F, 6'h21);
    repeat (8) @(posedge clk);
    #1;
    scen2 = 0;
    chk("s2_off_cycles", off_cnt, 5);
    chk("s2_stable", stable_bad, 0);
    chk("s2_in", 32'(input_enable), 32'h1E);
    chk("s2_out", 32'(output_enable), 32'h21);
    chk("s2_done_cnt", done_cnt, 1);

    // Repeated request changes nothing.
    req(6'h3F, 6'h21);
    @(negedge clk);
    chk("s3_done", 32'(done), 1);
    chk("s3_busy", 32'(busy), 0);
    chk("s3_in", 32'(input_enable), 32'h1E);
    chk("s3_out", 32'(output_enable), 32'h21);
    @(negedge clk);
    chk("s3_done_once", 32'(done), 0);

    // Second request held while first sequence runs.
    done_cnt = 0;
    saw_nr = 0;
    acc_done = 0;
    req(6'h3F, 6'h00);
    cfg_en = 6'h3F;
    cfg_dir = 6'h3F;
    cfg_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        acc_done = done;
        break;
      end
      saw_nr = 1;
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    chk("s4_not_ready", 32'(saw_nr), 1);
    chk("s4_done_at_accept", 32'(acc_done), 1);
    repeat (7) @(posedge clk);
    #1;
    chk("s4_in", 32'(input_enable), 0);
    chk("s4_out", 32'(output_enable), 32'h3F);
    chk("s4_done_cnt", done_cnt, 2);

    // Reset in the second settle cycle.
    req(6'h3F, 6'h3E);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("s5_in", 32'(input_enable), 0);
    chk("s5_out", 32'(output_enable), 0);
    chk("s5_ready", 32'(cfg_ready), 1);
    chk("s5_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s5_ready_after", 32'(cfg_ready), 1);
    req(6'h3F, 6'h0C);
    repeat (7) @(posedge clk);
    #1;
    chk("s5_rec_in", 32'(input_enable), 32'h33);
    chk("s5_rec_out", 32'(output_enable), 32'h0C);

`ifdef IBPL_SEQ_WATCHDOG_EN
    @(negedge clk);
    plugin_error = 1'b1;
    repeat (7) @(negedge clk);
    plugin_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("wd_burst7", 32'(fault), 0);
    plugin_error = 1'b1;
    repeat (8) @(negedge clk);
    plugin_error = 1'b0;
    repeat (2) @(negedge clk);
    chk("wd_fault", 32'(fault), 1);
    chk("wd_in", 32'(input_enable), 0);
    chk("wd_out", 32'(output_enable), 0);
    cfg_en = 6'h3F;
    cfg_dir = 6'h01;
    cfg_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("wd_ready", 32'(cfg_ready), 0);
    chk("wd_hold_in", 32'(input_enable), 0);
    chk("wd_hold_out", 32'(output_enable), 0);
    cfg_valid = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ibpl_dir_sequencer.md
# ibpl_dir_sequencer

Sequencer that owns the per-channel `input_enable` / `output_enable` vectors feeding an interbackplane cardlet. It applies direction and enable changes requested by the slave-register side with break-before-make: changed channels are disabled, held off for a settle time, then re-enabled in the new direction. A channel is therefore never driven as an output while the far side may still drive it, and the cardlet's direction-mismatch error is never produced by a reconfiguration. The block sits between the configuration registers and the cardlet instance.

## Interface
- `N_CH`, 6: number of cardlet channels.
- `SETTLE_CYC`, 16: settle time in clocks for which changed channels are held fully off. Legal range is at least 1.
- `ERR_CYC`, 8: number of consecutive `plugin_error` cycles that trips the watchdog. Only used with `IBPL_SEQ_WATCHDOG_EN`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: a configuration request is present.
- `cfg_ready` out 1: the block can accept a request.
- `cfg_dir` in N_CH: requested direction per channel, 1 = output, 0 = input.
- `cfg_en` in N_CH: requested enable per channel.
- `plugin_error` in 1: error flag from the cardlet.
- `input_enable` out N_CH: registered input enables to the cardlet.
- `output_enable` out N_CH: registered output enables to the cardlet.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a request has completed.
- `fault` out 1: watchdog fault, latched.

## Operation
- Target per channel c:
  - input enable = `cfg_en[c] & ~cfg_dir[c]`
  - output enable = `cfg_en[c] & cfg_dir[c]`
  - Invariant: `input_enable & output_enable` is 0 at all times.
- A request is accepted on `cfg_valid & cfg_ready`. At acceptance the block captures the targets and computes `chg` = the channels whose (input, output) pair differs from the current value.
- Requesters hold `cfg_valid` and the request data until accepted.
- States:
  - IDLE: `cfg_ready` = 1. On acceptance, go to BREAK if `chg` ≠ 0. If `chg` = 0, pulse `done` on the next cycle and stay in IDLE.
  - BREAK: clear both enables of the `chg` channels. Load the settle counter with `SETTLE_CYC-1`. Go to SETTLE.
  - SETTLE: decrement the counter each cycle. When it reaches 0, go to MAKE.
  - MAKE: write the target enables to the `chg` channels, pulse `done`, return to IDLE.
  - FAULT: exists only with the watchdog; see Configuration.
- Channels not in `chg` are never modified during a sequence.
- `cfg_ready` = 0 in BREAK, SETTLE, MAKE and FAULT.
- Reset, including mid-sequence, forces:
  - state IDLE and settle counter 0;
  - `input_enable` = 0, `output_enable` = 0;
  - `done` = 0, `fault` = 0, `busy` = 0.
  - `cfg_ready` = 1 from the first cycle after `rst` is released.

## Timing
- Let E0 be the accepting clock edge.
- Changed-channel enables read 0 after E0+1.
- The new values are visible after E0+SETTLE_CYC+2.
- Changed channels are therefore fully off for exactly SETTLE_CYC+1 cycles.
- `done` is high during the cycle after the MAKE edge. For a no-change request it is high during the cycle after E0.
- Back-to-back requests: the next acceptance can happen at the first IDLE cycle, which is the same cycle in which `done` is high.
- SETTLE_CYC = 1: SETTLE lasts one cycle.
- The settle counter width is `$clog2(SETTLE_CYC+1)`. The counter never wraps because it is only loaded in BREAK.

## Configuration
- Macro: `IBPL_SEQ_WATCHDOG_EN`.
- Defined:
  - In IDLE, an error counter counts consecutive cycles with `plugin_error` = 1. It clears when `plugin_error` is 0 or when the state is not IDLE.
  - When the count reaches `ERR_CYC`, on the next edge: all enables go to 0, `fault` goes to 1, state goes to FAULT.
  - FAULT ignores requests. The only exit is `rst`.
- Not defined:
  - `plugin_error` is ignored and `fault` is tied to 0.
  - No FAULT state and no error counter are built.

## Structure
- Package `ibpl_seq_pkg` holds:
  - the state enum `seq_state_t` (IDLE, BREAK, SETTLE, MAKE, FAULT);
  - the constants `DIR_IN` = 0 and `DIR_OUT` = 1.
- Sub-module `ibpl_settle_timer`: loadable down-counter with load, enable and a zero flag, parameterised by `SETTLE_CYC`.
- The top level holds the FSM, the change mask, the enable registers and the watchdog.

## Test plan
All scenarios use N_CH = 6, SETTLE_CYC = 4, ERR_CYC = 8.

- Reset, then request `cfg_en` = 6'h3F, `cfg_dir` = 6'h20:
  - after 6 cycles, `input_enable` = 6'h1F and `output_enable` = 6'h20;
  - exactly one `done` pulse.
- From that state, request `cfg_dir` = 6'h21:
  - only channel 0 drops to 0 for 5 cycles, then becomes an output;
  - channels 1–5 are stable throughout;
  - the invariant holds every cycle.
- Repeat the same request: `done` pulses the cycle after acceptance, `busy` stays 0, the enables are unchanged.
- Hold `cfg_valid` during SETTLE: `cfg_ready` = 0. The request is accepted in the cycle in which `done` is high, and both sequences complete in order.
- Assert `rst` in the second SETTLE cycle: all enables are 0 on the next cycle and the block is in IDLE with `cfg_ready` = 1.
- With `IBPL_SEQ_WATCHDOG_EN` defined, hold `plugin_error` for 8 cycles in IDLE:
  - `fault` = 1 and all enables are 0;
  - a subsequent request is not accepted;
  - a 7-cycle burst does not trip the watchdog.
